// File: rtl/alu8.sv
// ---------------------------------------------------------------------------
// alu8 : registered arithmetic/logic unit
//
// Computes one of eight operations on A/B/ci every cycle. The result, the
// carry/borrow/shift-out bit and a zero flag are registered, so they appear
// one rising clk edge after the inputs are sampled. There is no enable: the
// outputs update every cycle.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous active-high reset (result=0, co=0, zero=1)
//   op      in   3      operation select
//                       000 ADD, 001 SUB, 010 AND, 011 OR,
//                       100 XOR, 101 NOT, 110 SHL, 111 SHR
//   A       in   WIDTH  operand A
//   B       in   WIDTH  operand B
//   ci      in   1      carry-in / borrow-in / shift-in bit
//   result  out  WIDTH  registered result
//   co      out  1      registered carry-out / borrow-out / shift-out bit
//   zero    out  1      registered flag, 1 when the registered result is 0
// ---------------------------------------------------------------------------
module alu8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ci,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             zero
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // Arithmetic is done one bit wider than the operands so the extra MSB
    // carries the carry-out (ADD) or the borrow (SUB). For subtraction the
    // wrap of the extended difference sets that bit exactly when A < B + ci,
    // including the corner case A=0, B=all-ones, ci=1.
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;
    logic [WIDTH:0] ci_ext;

    assign ci_ext   = {{WIDTH{1'b0}}, ci};
    assign sum_ext  = {1'b0, A} + {1'b0, B} + ci_ext;
    assign diff_ext = {1'b0, A} - {1'b0, B} - ci_ext;

    // Bitwise operations, built per bit.
    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] or_bits;
    logic [WIDTH-1:0] xor_bits;
    logic [WIDTH-1:0] not_bits;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bitwise
            assign and_bits[gi] = A[gi] & B[gi];
            assign or_bits[gi]  = A[gi] | B[gi];
            assign xor_bits[gi] = A[gi] ^ B[gi];
            assign not_bits[gi] = ~A[gi];
        end
    endgenerate

    logic [WIDTH-1:0] result_next;
    logic             co_next;
    logic             zero_next;

    always_comb begin
        result_next = '0;
        co_next     = 1'b0;
        case (op)
            OP_ADD: begin
                result_next = sum_ext[WIDTH-1:0];
                co_next     = sum_ext[WIDTH];
            end
            OP_SUB: begin
                result_next = diff_ext[WIDTH-1:0];
                co_next     = diff_ext[WIDTH];
            end
            OP_AND: result_next = and_bits;
            OP_OR:  result_next = or_bits;
            OP_XOR: result_next = xor_bits;
            OP_NOT: result_next = not_bits;
            OP_SHL: begin
                result_next = {A[WIDTH-2:0], ci};
                co_next     = A[WIDTH-1];
            end
            OP_SHR: begin
                result_next = {ci, A[WIDTH-1:1]};
                co_next     = A[0];
            end
            default: begin
                result_next = '0;
                co_next     = 1'b0;
            end
        endcase
    end

    // Zero flag is derived from the value about to be registered so it can
    // never disagree with the registered result.
    assign zero_next = (result_next == '0);

    logic [WIDTH-1:0] result_reg;
    logic             co_reg;
    logic             zero_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg <= '0;
            co_reg     <= 1'b0;
            zero_reg   <= 1'b1;
        end else begin
            result_reg <= result_next;
            co_reg     <= co_next;
            zero_reg   <= zero_next;
        end
    end

    assign result = result_reg;
    assign co     = co_reg;
    assign zero   = zero_reg;

endmodule

// File: tb/tb_alu8.sv
// ---------------------------------------------------------------------------
// tb_alu8 : self-checking bench for alu8
//
// Expected results are pushed to a scoreboard queue when stimulus is driven
// and popped when the DUT output for that stimulus is due (one edge later).
// ---------------------------------------------------------------------------
module tb_alu8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] op  = 3'b000;
    logic [7:0] A   = 8'h00;
    logic [7:0] B   = 8'h00;
    logic       ci  = 1'b0;
    logic [7:0] result;
    logic       co;
    logic       zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       z;
        string      name;
    } exp_t;

    exp_t sb[$];

    alu8 #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .op     (op),
        .A      (A),
        .B      (B),
        .ci     (ci),
        .result (result),
        .co     (co),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    // Independent reference model written in integer arithmetic.
    function automatic void model(input logic [2:0] o, input logic [7:0] a,
                                  input logic [7:0] b, input logic c,
                                  output logic [7:0] r, output logic co_o);
        int ai, bi, ciint, t;
        ai = int'(a);
        bi = int'(b);
        ciint = c ? 1 : 0;
        co_o = 1'b0;
        case (o)
            3'd0: begin t = ai + bi + ciint; r = 8'(t % 256); co_o = (t > 255); end
            3'd1: begin t = ai - bi - ciint; r = 8'((t + 512) % 256); co_o = (t < 0); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = 8'(255 - ai);
            3'd6: begin r = 8'((ai * 2 + ciint) % 256); co_o = (ai >= 128); end
            default: begin r = 8'(ai / 2 + ciint * 128); co_o = (ai % 2 == 1); end
        endcase
    endfunction

    // Drive one operation and push the given expectation.
    task automatic drive(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic [7:0] er, input logic ec,
                         input logic ez, input string nm);
        exp_t e;
        e.r = er;
        e.c = ec;
        e.z = ez;
        e.name = nm;
        op = o;
        A  = a;
        B  = b;
        ci = c;
        sb.push_back(e);
    endtask

    // Wait for the next edge and compare the oldest expectation.
    task automatic collect();
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got result=%02h co=%0b zero=%0b, required a queued expectation",
                     result, co, zero);
        end else begin
            e = sb.pop_front();
            if ({result, co, zero} !== {e.r, e.c, e.z}) begin
                failures++;
                $display("FAIL %s: got result=%02h co=%0b zero=%0b, required result=%02h co=%0b zero=%0b",
                         e.name, result, co, zero, e.r, e.c, e.z);
            end else begin
                $display("ok   %s: result=%02h co=%0b zero=%0b", e.name, result, co, zero);
            end
        end
    endtask

    task automatic test_reset();
        op = 3'b000; A = 8'h55; B = 8'hAA; ci = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({result, co, zero} !== {8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_pre_edge: got result=%02h co=%0b zero=%0b, required 00/0/1", result, co, zero);
        end else $display("ok   reset_pre_edge");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({result, co, zero} !== {8'h00, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL reset_held_%0d: got result=%02h co=%0b zero=%0b, required 00/0/1",
                         i, result, co, zero);
            end else $display("ok   reset_held_%0d", i);
        end
        rst = 1'b0;
        drive(3'b000, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0, "reset_release");
        collect();
    endtask

    task automatic test_add();
        drive(3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, "add_carry");    collect();
        drive(3'b000, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, "add_ci");       collect();
        drive(3'b000, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, "add_wrap_ci");  collect();
    endtask

    task automatic test_sub();
        drive(3'b001, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, "sub_plain");    collect();
        drive(3'b001, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "sub_borrow");   collect();
        drive(3'b001, 8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b1, "sub_zero");     collect();
        drive(3'b001, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, "sub_max_bor");  collect();
    endtask

    task automatic test_logic();
        drive(3'b010, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, "and");  collect();
        drive(3'b011, 8'hF0, 8'h3C, 1'b1, 8'hFC, 1'b0, 1'b0, "or");   collect();
        drive(3'b100, 8'hF0, 8'h3C, 1'b1, 8'hCC, 1'b0, 1'b0, "xor");  collect();
        drive(3'b101, 8'hF0, 8'h3C, 1'b1, 8'h0F, 1'b0, 1'b0, "not");  collect();
    endtask

    task automatic test_shift();
        drive(3'b110, 8'h81, 8'hFF, 1'b1, 8'h03, 1'b1, 1'b0, "shl");      collect();
        drive(3'b111, 8'h81, 8'hFF, 1'b0, 8'h40, 1'b1, 1'b0, "shr");      collect();
        drive(3'b111, 8'h02, 8'h00, 1'b1, 8'h81, 1'b0, 1'b0, "shr_ci");   collect();
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b, er;
        logic       c, ec;
        // Inputs change every cycle; each collect() lands on the very next edge.
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            c = 1'($urandom_range(0, 1));
            model(3'(i), a, b, c, er, ec);
            drive(3'(i), a, b, c, er, ec, (er == 8'h00), $sformatf("b2b_op%0d", i));
            collect();
        end
        // Reset between edges: outputs must clear without waiting for clk.
        a = 8'h7F; b = 8'h01; c = 1'b0;
        drive(3'b000, a, b, c, 8'h80, 1'b0, 1'b0, "b2b_after_reset");
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({result, co, zero} !== {8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL midreset_async: got result=%02h co=%0b zero=%0b, required 00/0/1", result, co, zero);
        end else $display("ok   midreset_async");
        sb.delete();  // in-flight op is discarded
        @(posedge clk);
        #1;
        checks++;
        if ({result, co, zero} !== {8'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL midreset_held: got result=%02h co=%0b zero=%0b, required 00/0/1", result, co, zero);
        end else $display("ok   midreset_held");
        rst = 1'b0;
        drive(3'b000, a, b, c, 8'h80, 1'b0, 1'b0, "b2b_after_reset");
        collect();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, required completion", $time);
        $fatal(1, "timeout");
    end

endmodule
